// File: rtl/ccff_pkg.sv
// Shared types and constants for the configuration-chain readback engine.
package ccff_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ccff_state_e;

    localparam int CKSUM_W = 16;

    // Modular accumulate; wrap-around at 2^CKSUM_W is intended.
    function automatic logic [CKSUM_W-1:0] cksum_add(input logic [CKSUM_W-1:0] acc,
                                                     input logic [CKSUM_W-1:0] word);
        return acc + word;
    endfunction

endpackage

// File: rtl/ccff_rd_outreg.sv
// Single-entry output holding register with valid/ready handshake; load_ok tells
// the producer it may load this cycle (register empty or draining now).
module ccff_rd_outreg
    import ccff_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         rd_ready,
    output logic         rd_valid,
    output logic [W-1:0] rd_data,
    output logic         load_ok,
    output logic         xfer
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    assign xfer     = valid_q & rd_ready;
    assign load_ok  = ~valid_q | rd_ready;
    assign rd_valid = valid_q;
    assign rd_data  = data_q;

    // Next-state for the holding register; flush wins over load and transfer.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (xfer) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Holding register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= {W{1'b0}};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/ccff_readback.sv
// Configuration-chain readback: shifts NUM_CHAINS parallel chains CHAIN_LEN times,
// streams each tail word out over valid/ready, optionally recirculating it back.
module ccff_readback
    import ccff_pkg::*;
#(
    parameter int NUM_CHAINS = 8,
    parameter int CHAIN_LEN  = 1024
) (
    input  logic                  prog_clk,
    input  logic                  prog_reset_n,
    input  logic                  start,
    input  logic                  restore,
    input  logic                  abort,
    input  logic [NUM_CHAINS-1:0] ccff_tail,
    output logic [NUM_CHAINS-1:0] ccff_head,
    output logic                  ccff_shift_en,
    output logic [NUM_CHAINS-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  busy,
    output logic                  done,
    output logic [CKSUM_W-1:0]    checksum
);

    localparam int            CNT_W    = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

    ccff_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CKSUM_W-1:0]   cksum_q, cksum_d;
    logic                 restore_q, restore_d;

    logic                 load_ok_s;
    logic                 xfer_s;
    logic [CKSUM_W-1:0]   word_ext_s;

    // Abort must kill the shift in the same cycle, so shift_en stays combinational.
    assign ccff_shift_en = (state_q == ST_SHIFT) & load_ok_s & ~abort;
    assign ccff_head     = (ccff_shift_en & restore_q) ? ccff_tail : {NUM_CHAINS{1'b0}};
    assign word_ext_s    = CKSUM_W'(rd_data);
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign checksum      = cksum_q;

    ccff_rd_outreg #(
        .W (NUM_CHAINS)
    ) u_outreg (
        .clk       (prog_clk),
        .rst_n     (prog_reset_n),
        .flush     (abort),
        .load      (ccff_shift_en),
        .load_data (ccff_tail),
        .rd_ready  (rd_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .load_ok   (load_ok_s),
        .xfer      (xfer_s)
    );

    // Pass sequencing, shift counting and checksum accumulation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cksum_d   = cksum_q;
        restore_d = restore_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d   = ST_SHIFT;
                        cnt_d     = {CNT_W{1'b0}};
                        cksum_d   = {CKSUM_W{1'b0}};
                        restore_d = restore;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (ccff_shift_en && (cnt_q == CNT_LAST)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
                ST_DRAIN: begin
                    if (xfer_s) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
            if (ccff_shift_en) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d = cnt_d;
            end
            if (xfer_s && (state_q != ST_IDLE)) begin
                cksum_d = cksum_add(cksum_q, word_ext_s);
            end else begin
                cksum_d = cksum_d;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            cksum_q   <= {CKSUM_W{1'b0}};
            restore_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cksum_q   <= cksum_d;
            restore_q <= restore_d;
        end
    end

endmodule

// File: tb/tb_ccff_readback.sv
// Scoreboard bench for ccff_readback with a behavioural 4-deep, 8-wide chain fabric.
module tb_ccff_readback;

    localparam int NC = 8;
    localparam int CL = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          restore = 1'b0;
    logic          abort = 1'b0;
    logic          rd_ready = 1'b0;
    logic [NC-1:0] tail, head, rd_data;
    logic          shift_en, rd_valid, busy, done;
    logic [15:0]   checksum;

    logic [NC-1:0] mem [0:CL-1];
    logic [NC-1:0] pre [0:CL-1];
    logic          preload_en = 1'b0;
    logic [NC-1:0] exp_q [$];

    int checks = 0;
    int failures = 0;
    int cyc;
    int dones;
    int done_at;

    always #5 clk = ~clk;

    ccff_readback #(
        .NUM_CHAINS (NC),
        .CHAIN_LEN  (CL)
    ) dut (
        .prog_clk      (clk),
        .prog_reset_n  (rst_n),
        .start         (start),
        .restore       (restore),
        .abort         (abort),
        .ccff_tail     (tail),
        .ccff_head     (head),
        .ccff_shift_en (shift_en),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .busy          (busy),
        .done          (done),
        .checksum      (checksum)
    );

    // Fabric: mem[0] is the tail bit-slice, head enters at the far end.
    assign tail = mem[0];
    always @(posedge clk) begin
        if (preload_en) begin
            for (int i = 0; i < CL; i++) mem[i] <= pre[i];
        end else if (shift_en) begin
            for (int i = 0; i < CL - 1; i++) mem[i] <= mem[i+1];
            mem[CL-1] <= head;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted word is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (rst_n && rd_valid && rd_ready && !abort) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word: got 0x%0h expected none", rd_data);
            end else begin
                check("word", {24'd0, rd_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic preload(input logic [7:0] w0, input logic [7:0] w1,
                           input logic [7:0] w2, input logic [7:0] w3);
        pre[0] = w0; pre[1] = w1; pre[2] = w2; pre[3] = w3;
        preload_en = 1'b1;
        tick();
        preload_en = 1'b0;
    endtask

    task automatic push4(input logic [7:0] w0, input logic [7:0] w1,
                         input logic [7:0] w2, input logic [7:0] w3);
        exp_q.push_back(w0); exp_q.push_back(w1);
        exp_q.push_back(w2); exp_q.push_back(w3);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_shift_en"}, {31'd0, shift_en}, 32'd0);
        check({tag, "_head"}, {24'd0, head}, 32'd0);
        check({tag, "_rd_valid"}, {31'd0, rd_valid}, 32'd0);
        check({tag, "_rd_data"}, {24'd0, rd_data}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_checksum"}, {16'd0, checksum}, 32'd0);
    endtask

    // Start cycle is cycle 0; waits (bounded) for done and checks its cycle.
    task automatic run_pass(input logic r, input int exp_cyc, input string tag);
        start = 1'b1;
        restore = r;
        cyc = 0;
        tick();
        start = 1'b0;
        while (!done && cyc < 40) tick();
        check({tag, "_done_cycle"}, cyc, exp_cyc);
        tick();
        check({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
        check({tag, "_queue_drained"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        rd_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;
        tick();

        // Non-destructive readback.
        preload(8'h11, 8'h22, 8'h33, 8'h44);
        push4(8'h11, 8'h22, 8'h33, 8'h44);
        run_pass(1'b1, 6, "restore");
        check("restore_checksum", {16'd0, checksum}, 32'h00AA);
        check("restore_chain0", {24'd0, mem[0]}, 32'h11);
        check("restore_chain1", {24'd0, mem[1]}, 32'h22);
        check("restore_chain2", {24'd0, mem[2]}, 32'h33);
        check("restore_chain3", {24'd0, mem[3]}, 32'h44);

        // Destructive readback, then the chain must read back empty.
        preload(8'h11, 8'h22, 8'h33, 8'h44);
        push4(8'h11, 8'h22, 8'h33, 8'h44);
        run_pass(1'b0, 6, "destr");
        check("destr_checksum", {16'd0, checksum}, 32'h00AA);
        push4(8'h00, 8'h00, 8'h00, 8'h00);
        run_pass(1'b0, 6, "second");
        check("second_checksum", {16'd0, checksum}, 32'h0000);

        // Backpressure: three stall cycles on the first word.
        preload(8'h11, 8'h22, 8'h33, 8'h44);
        push4(8'h11, 8'h22, 8'h33, 8'h44);
        rd_ready = 1'b0;
        start = 1'b1;
        restore = 1'b1;
        cyc = 0;
        tick();
        start = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            check("stall_valid", {31'd0, rd_valid}, 32'd1);
            check("stall_data", {24'd0, rd_data}, 32'h11);
            check("stall_shift_en", {31'd0, shift_en}, 32'd0);
            tick();
        end
        rd_ready = 1'b1;
        while (!done && cyc < 40) tick();
        check("stall_done_cycle", cyc, 32'd9);
        tick();
        check("stall_checksum", {16'd0, checksum}, 32'h00AA);
        check("stall_queue_drained", exp_q.size(), 32'd0);

        // Abort one cycle after the second transfer.
        preload(8'h11, 8'h22, 8'h33, 8'h44);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        start = 1'b1;
        restore = 1'b1;
        cyc = 0;
        tick();
        start = 1'b0;
        repeat (3) tick();
        abort = 1'b1;
        #1;
        check("abort_shift_en", {31'd0, shift_en}, 32'd0);
        tick();
        abort = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_rd_valid", {31'd0, rd_valid}, 32'd0);
        dones = 0;
        for (int k = 0; k < 5; k++) begin
            if (done) dones++;
            tick();
        end
        check("abort_no_done", dones, 32'd0);
        check("abort_checksum", {16'd0, checksum}, 32'h0033);
        check("abort_queue_drained", exp_q.size(), 32'd0);

        // Reset in the middle of SHIFT, then a clean full pass.
        preload(8'h11, 8'h22, 8'h33, 8'h44);
        start = 1'b1;
        restore = 1'b1;
        cyc = 0;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check_reset_vals("midreset");
        tick();
        rst_n = 1'b1;
        tick();
        preload(8'h11, 8'h22, 8'h33, 8'h44);
        push4(8'h11, 8'h22, 8'h33, 8'h44);
        run_pass(1'b1, 6, "postreset");
        check("postreset_checksum", {16'd0, checksum}, 32'h00AA);

        // Start pulsed during DRAIN must be ignored.
        preload(8'h11, 8'h22, 8'h33, 8'h44);
        push4(8'h11, 8'h22, 8'h33, 8'h44);
        start = 1'b1;
        restore = 1'b1;
        cyc = 0;
        tick();
        dones = 0;
        done_at = 0;
        while (cyc < 12) begin
            start = (cyc == 5);
            if (done) begin
                dones++;
                done_at = cyc;
            end
            tick();
        end
        start = 1'b0;
        check("drainstart_done_count", dones, 32'd1);
        check("drainstart_done_cycle", done_at, 32'd6);
        check("drainstart_idle", {31'd0, busy}, 32'd0);
        check("drainstart_checksum", {16'd0, checksum}, 32'h00AA);
        check("drainstart_queue_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
